triangle_analyzer: RTL

- Consumer-side counterpart to the team's triangle wave source: ingests a sample stream qualified by ena and recovers the waveform's shape.
- Tracks ramp direction and reports peak and trough values, peak-to-peak period in samples, and lock status.
- Flags any non-unit step as a malformed triangle.
- Sits downstream of a waveform source in self-check and loopback benches and on-chip monitors.

---
 rtl/triangle_analyzer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/triangle_analyzer.sv
`default_nettype none
// ============================================================================
//  Module   : triangle_analyzer
//  Purpose  : Recovers the shape of a triangle-wave sample stream. Tracks the
//             ramp direction, reports peak/trough values, the peak-to-peak
//             period in samples and a lock indication, and flags any sample
//             that is not a unit step away from its predecessor.
//  Ports    :
//    clk          in   system clock, rising edge
//    rst          in   asynchronous reset, active-low (0 = reset)
//    ena          in   sample qualifier; in is accepted on a rising edge
//    in           in   [N-1:0] unsigned sample value
//    peak_valid   out  one-cycle pulse, local maximum detected
//    peak         out  [N-1:0] most recent local maximum
//    trough_valid out  one-cycle pulse, local minimum detected
//    trough       out  [N-1:0] most recent local minimum
//    period_valid out  one-cycle pulse, new measurement on period
//    period       out  [P-1:0] samples between the two most recent peaks
//    locked       out  last two periods equal and no step error seen
//    step_err     out  sticky, a non-unit step was observed
//  Revision : 1.0  initial release
// ============================================================================
module triangle_analyzer #(
    parameter int N = 8,
    parameter int P = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] in,
    output logic         peak_valid,
    output logic [N-1:0] peak,
    output logic         trough_valid,
    output logic [N-1:0] trough,
    output logic         period_valid,
    output logic [P-1:0] period,
    output logic         locked,
    output logic         step_err
);

    localparam logic [P-1:0] C_P_MAX = {P{1'b1}};

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_SEEDED = 2'd1,
        S_UP     = 2'd2,
        S_DOWN   = 2'd3
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_prev;
    logic [P-1:0] r_cnt;
    logic         r_have_peak;
    logic [P-1:0] r_last_period;

    logic         r_peak_valid;
    logic [N-1:0] r_peak;
    logic         r_trough_valid;
    logic [N-1:0] r_trough;
    logic         r_period_valid;
    logic [P-1:0] r_period;
    logic         r_locked;
    logic         r_step_err;

    // Compare in one extra bit so neither the +1 nor the ordering wraps:
    // a jump from all-ones to zero is a plain fall and a step error.
    logic [N:0]   w_in_x;
    logic [N:0]   w_prev_x;
    logic         w_rise;
    logic         w_fall;
    logic         w_unit;
    logic         w_bad;
    logic         w_peak_det;
    logic         w_trough_det;
    logic [P-1:0] w_cnt_inc;
    state_t       w_next_state;

    assign w_in_x   = {1'b0, in};
    assign w_prev_x = {1'b0, r_prev};
    assign w_rise   = (w_in_x > w_prev_x);
    assign w_fall   = (w_in_x < w_prev_x);
    assign w_unit   = (w_in_x == w_prev_x + (N+1)'(1)) ||
                      (w_prev_x == w_in_x + (N+1)'(1));

    // The seed sample has no predecessor, so it is never checked.
    assign w_bad        = ena && (r_state != S_EMPTY) && !w_unit;
    assign w_peak_det   = ena && (r_state == S_UP)   && w_fall;
    assign w_trough_det = ena && (r_state == S_DOWN) && w_rise;

    // Saturating increment; also equals min(cnt+1, max), i.e. the period
    // value reported when this sample closes a peak-to-peak interval.
    assign w_cnt_inc = (r_cnt == C_P_MAX) ? r_cnt : r_cnt + P'(1);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY:  w_next_state = S_SEEDED;
            S_SEEDED: begin
                if (w_rise)      w_next_state = S_UP;
                else if (w_fall) w_next_state = S_DOWN;
            end
            S_UP:     if (w_fall) w_next_state = S_DOWN;
            S_DOWN:   if (w_rise) w_next_state = S_UP;
            default:  w_next_state = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_EMPTY;
            r_prev         <= '0;
            r_cnt          <= '0;
            r_have_peak    <= 1'b0;
            r_last_period  <= '0;
            r_peak_valid   <= 1'b0;
            r_peak         <= '0;
            r_trough_valid <= 1'b0;
            r_trough       <= '0;
            r_period_valid <= 1'b0;
            r_period       <= '0;
            r_locked       <= 1'b0;
            r_step_err     <= 1'b0;
        end else begin
            r_peak_valid   <= 1'b0;
            r_trough_valid <= 1'b0;
            r_period_valid <= 1'b0;
            if (ena) begin
                r_prev  <= in;
                r_state <= w_next_state;

                if (w_bad) begin
                    r_step_err <= 1'b1;
                    r_locked   <= 1'b0;
                end

                if (w_peak_det) begin
                    r_peak_valid <= 1'b1;
                    r_peak       <= r_prev;
                    r_cnt        <= '0;
                    r_have_peak  <= 1'b1;
                    // First peak only opens the interval; later peaks close it.
                    if (r_have_peak) begin
                        r_period       <= w_cnt_inc;
                        r_period_valid <= 1'b1;
                        r_last_period  <= w_cnt_inc;
                        r_locked       <= (w_cnt_inc == r_last_period) &&
                                          !r_step_err && !w_bad;
                    end
                end else begin
                    r_cnt <= w_cnt_inc;
                end

                if (w_trough_det) begin
                    r_trough_valid <= 1'b1;
                    r_trough       <= r_prev;
                end
            end
        end
    end

    assign peak_valid   = r_peak_valid;
    assign peak         = r_peak;
    assign trough_valid = r_trough_valid;
    assign trough       = r_trough;
    assign period_valid = r_period_valid;
    assign period       = r_period;
    assign locked       = r_locked;
    assign step_err     = r_step_err;

endmodule
`default_nettype wire
